kinase_valve_sequencer: RTL
===========================

KINASE_VALVE_SEQUENCER -- requirements
Module: kinase_valve_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the step-period divider.
REQ-002 SHALL have parameter STK_W, default 8, width of the stroke counts.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: terminate the run; overrides start.
REQ-007 SHALL have port lane_b, input, 1 bit: 0 selects lane a, 1 selects lane b; sampled at start.
REQ-008 SHALL have port step_div, input, DIV_W bits: step period minus 1, in clocks; sampled at start.
REQ-009 SHALL have ports load_stk, mix_stk, flush_stk, input, STK_W bits each: stroke counts per phase; sampled at start.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-012 SHALL have port c_valve, output, 13 bits: control valves c1..c13 on bits 0..12; 1 = pressurized/closed.
REQ-013 SHALL have port s_valve, output, 4 bits: sieve valves s1..s4; 1 = sieve engaged.
REQ-014 SHALL have port p_valve, output, 5 bits: bits 0..2 are peristaltic phases p1..p3, bits 3..4 are p4/p5 lane isolation; 1 = closed.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, MIX, FLUSH, with order IDLE->LOAD->MIX->FLUSH->IDLE.
REQ-016 SHALL, in IDLE with start=1 and abort=0, capture all sampled inputs and enter LOAD on the next edge.
REQ-017 SHALL generate a step tick every step_div+1 clocks while busy; step_div=0 gives a tick every clock.
REQ-018 SHALL advance the peristaltic phase on each tick through p_valve[2:0] = 110,100,101,001,011,010, repeating.
REQ-019 SHALL hold the phase at 111 outside a running phase; one stroke equals 6 ticks.
REQ-020 SHALL leave a phase on the tick completing its programmed stroke count; a phase with count 0 SHALL be skipped, costing 1 cycle and no ticks.
REQ-021 SHALL, in LOAD, open the inlets of the selected lane (c1..c3 for a, c4..c6 for b, driven 0) and hold all other c bits at 1.
REQ-022 SHALL, in MIX, open the ring valves c9..c13 and close all inlets and outlets.
REQ-023 SHALL, in FLUSH, open the selected lane outlet (c7 for a, c8 for b) and close all inlets and ring valves.
REQ-024 SHALL drive p_valve[3] = 0 while lane a is active and p_valve[4] = 0 while lane b is active; both SHALL be 1 in IDLE.
REQ-025 SHALL pulse done for 1 cycle on the FLUSH->IDLE transition, with busy low in that same cycle.
REQ-026 SHALL ignore start while busy, and SHALL NOT change captured values mid-run.
REQ-027 SHALL, on abort while busy, enter IDLE on the next edge with all valves closed (all 1) and no done pulse.
REQ-028 SHALL apply the same rule to abort and start asserted together in IDLE: the request is ignored.
REQ-029 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, on rst_n low at any time, asynchronously force IDLE and set c_valve=all 1, p_valve=all 1, s_valve=0, busy=0, done=0, and clear the counters.
REQ-031 SHALL treat reset mid-run as abort, never emitting done.

Configuration
REQ-032 SHALL gate the sieve with macro KVS_SIEVE_EN.
- Defined: s_valve = 1111 in LOAD and MIX, 0000 in IDLE and FLUSH.
- Undefined: s_valve is constant 0000 and the sieve logic is absent.

Verification
REQ-033 SHALL cover: step_div=0, load/mix/flush=1/1/1, lane a -> busy for 1+18 cycles, c1..c3=0 during LOAD, done on the final edge.
REQ-034 SHALL cover: step_div=3, mix_stk=2 -> MIX lasts 48 clocks and p_valve[2:0] steps every 4 clocks in the REQ-018 order.
REQ-035 SHALL cover: lane_b=1 -> c4..c6 open in LOAD, c8 open in FLUSH, p_valve[4]=0 and p_valve[3]=1.
REQ-036 SHALL cover: mix_stk=0 -> MIX is occupied for exactly 1 cycle and has no ticks.
REQ-037 SHALL cover: abort mid-MIX -> IDLE next cycle, outputs all closed, done stays 0; a start asserted during the run has no effect.
REQ-038 SHALL cover: rst_n low mid-LOAD -> outputs take reset values immediately; KVS_SIEVE_EN builds give s_valve=1111 in LOAD, non-EN builds give 0000.

Source files
------------

// File: rtl/kinase_valve_sequencer.sv
// Valve sequencer for a two-lane microfluidic kinase chip: LOAD -> MIX -> FLUSH.
// Optional sieve drive is enabled by defining KVS_SIEVE_EN.
module kinase_valve_sequencer #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned STK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             lane_b,
  input  logic [DIV_W-1:0] step_div,
  input  logic [STK_W-1:0] load_stk,
  input  logic [STK_W-1:0] mix_stk,
  input  logic [STK_W-1:0] flush_stk,
  output logic             busy,
  output logic             done,
  output logic [12:0]      c_valve,
  output logic [3:0]       s_valve,
  output logic [4:0]       p_valve
);

  localparam int unsigned PH_W = 3;
  localparam int unsigned CV_W = 13;
  localparam int unsigned PV_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MIX   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              lane_q, lane_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [STK_W-1:0]  load_q, load_d;
  logic [STK_W-1:0]  mix_q, mix_d;
  logic [STK_W-1:0]  flush_q, flush_d;
  logic              first_q, first_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [STK_W-1:0]  stk_cnt_q, stk_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CV_W-1:0]   c_valve_q, c_valve_d;
  logic [PV_W-1:0]   p_valve_q, p_valve_d;

  logic [STK_W-1:0]  cur_stk;
  logic [STK_W-1:0]  nxt_stk;
  logic              run;
  logic              tick;

  function automatic logic [PH_W-1:0] ph_pat(input logic [PH_W-1:0] idx);
    case (idx)
      3'd0:    ph_pat = 3'b110;
      3'd1:    ph_pat = 3'b100;
      3'd2:    ph_pat = 3'b101;
      3'd3:    ph_pat = 3'b001;
      3'd4:    ph_pat = 3'b011;
      3'd5:    ph_pat = 3'b010;
      default: ph_pat = 3'b111;
    endcase
  endfunction

  function automatic logic [STK_W-1:0] phase_stk(input state_e s, input logic [STK_W-1:0] l,
                                                 input logic [STK_W-1:0] m,
                                                 input logic [STK_W-1:0] f);
    case (s)
      S_LOAD:  phase_stk = l;
      S_MIX:   phase_stk = m;
      S_FLUSH: phase_stk = f;
      default: phase_stk = '0;
    endcase
  endfunction

  function automatic state_e next_phase(input state_e s);
    case (s)
      S_LOAD:  next_phase = S_MIX;
      S_MIX:   next_phase = S_FLUSH;
      default: next_phase = S_IDLE;
    endcase
  endfunction

  // Sequencing, step divider and output decode.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    div_d     = div_q;
    load_d    = load_q;
    mix_d     = mix_q;
    flush_d   = flush_q;
    first_d   = 1'b0;
    div_cnt_d = div_cnt_q;
    ph_d      = ph_q;
    stk_cnt_d = stk_cnt_q;
    done_d    = 1'b0;

    cur_stk = phase_stk(state_q, load_q, mix_q, flush_q);
    // The first run cycle primes the divider, so it never ticks.
    run     = (state_q != S_IDLE) && !first_q && (cur_stk != '0);
    tick    = run && (div_cnt_q == div_q);

    if (state_q == S_IDLE) begin
      if (start && !abort) begin
        state_d   = S_LOAD;
        lane_d    = lane_b;
        div_d     = step_div;
        load_d    = load_stk;
        mix_d     = mix_stk;
        flush_d   = flush_stk;
        first_d   = 1'b1;
        div_cnt_d = '0;
        ph_d      = '0;
        stk_cnt_d = '0;
      end
    end else if (abort) begin
      state_d   = S_IDLE;
      div_cnt_d = '0;
      ph_d      = '0;
      stk_cnt_d = '0;
    end else if (cur_stk == '0 ||
                 (tick && ph_q == 3'd5 && (stk_cnt_q + STK_W'(1)) == cur_stk)) begin
      state_d   = next_phase(state_q);
      done_d    = (state_q == S_FLUSH);
      div_cnt_d = '0;
      ph_d      = '0;
      stk_cnt_d = '0;
    end else if (tick) begin
      div_cnt_d = '0;
      if (ph_q == 3'd5) begin
        ph_d      = '0;
        stk_cnt_d = stk_cnt_q + STK_W'(1);
      end else begin
        ph_d = ph_q + PH_W'(1);
      end
    end else if (run) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    nxt_stk   = phase_stk(state_d, load_d, mix_d, flush_d);
    busy_d    = (state_d != S_IDLE);
    c_valve_d = '1;
    p_valve_d = '1;
    case (state_d)
      S_LOAD: begin
        if (lane_d) c_valve_d[5:3] = 3'b000;
        else        c_valve_d[2:0] = 3'b000;
      end
      S_MIX:   c_valve_d[12:8] = 5'b00000;
      S_FLUSH: begin
        if (lane_d) c_valve_d[7] = 1'b0;
        else        c_valve_d[6] = 1'b0;
      end
      default: ;
    endcase
    if (state_d != S_IDLE) begin
      p_valve_d[3] = lane_d;
      p_valve_d[4] = ~lane_d;
      if (nxt_stk != '0) p_valve_d[2:0] = ph_pat(ph_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lane_q    <= 1'b0;
      div_q     <= '0;
      load_q    <= '0;
      mix_q     <= '0;
      flush_q   <= '0;
      first_q   <= 1'b0;
      div_cnt_q <= '0;
      ph_q      <= '0;
      stk_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      c_valve_q <= '1;
      p_valve_q <= '1;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      div_q     <= div_d;
      load_q    <= load_d;
      mix_q     <= mix_d;
      flush_q   <= flush_d;
      first_q   <= first_d;
      div_cnt_q <= div_cnt_d;
      ph_q      <= ph_d;
      stk_cnt_q <= stk_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      c_valve_q <= c_valve_d;
      p_valve_q <= p_valve_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign c_valve = c_valve_q;
  assign p_valve = p_valve_q;

`ifdef KVS_SIEVE_EN
  logic [3:0] s_valve_q, s_valve_d;

  // Sieve engaged while sample is being loaded or mixed.
  always_comb begin
    s_valve_d = 4'b0000;
    if (state_d == S_LOAD || state_d == S_MIX) s_valve_d = 4'b1111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_valve_q <= 4'b0000;
    else        s_valve_q <= s_valve_d;
  end

  assign s_valve = s_valve_q;
`else
  assign s_valve = 4'b0000;
`endif

endmodule
